// File: rtl/reg_wb_queue_pkg.sv
// Shared core definitions for the writeback queue: register-index and data widths
// and the queued writeback entry.
package reg_wb_queue_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_queue.sv
// Merges ALU and load-unit writebacks into one register-file write port through a small FIFO,
// and forwards pending (queued, not yet written) values to the current read addresses.
module reg_wb_queue
  import reg_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              a_valid,
  input  logic [REG_W-1:0]  a_rd,
  input  logic [DATA_W-1:0] a_wd,
  output logic              a_ready,
  input  logic              m_valid,
  input  logic [REG_W-1:0]  m_rd,
  input  logic [DATA_W-1:0] m_wd,
  output logic              m_ready,
  output logic              we,
  output logic [REG_W-1:0]  rd,
  output logic [DATA_W-1:0] wd,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] free;
  logic             push_a, push_m, pop;
  wb_entry_t        head;

  // Free space ignores a same-cycle pop so ready never depends on the write port.
  assign free    = CNT_W'(DEPTH) - count_q;
  assign a_ready = (free != '0);
  assign m_ready = (free >= CNT_W'(2)) || ((free != '0) && !a_valid);

  // Writes to x0 complete the handshake but are never queued.
  assign push_a = a_valid && a_ready && (a_rd != '0);
  assign push_m = m_valid && m_ready && (m_rd != '0);
  assign pop    = (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push_a) begin
      mem_d[wr_ptr_d] = '{rd: a_rd, wd: a_wd};
      wr_ptr_d        = wr_ptr_d + PTR_W'(1);
    end
    if (push_m) begin
      mem_d[wr_ptr_d] = '{rd: m_rd, wd: m_wd};
      wr_ptr_d        = wr_ptr_d + PTR_W'(1);
    end
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push_a) + CNT_W'(push_m) - CNT_W'(pop);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign we    = pop;
  assign rd    = pop ? head.rd : '0;
  assign wd    = pop ? head.wd : '0;
  assign count = count_q;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        if ((rs1 != '0) && (mem_q[rd_ptr_q + PTR_W'(i)].rd == rs1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = mem_q[rd_ptr_q + PTR_W'(i)].wd;
        end
        if ((rs2 != '0) && (mem_q[rd_ptr_q + PTR_W'(i)].rd == rs2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = mem_q[rd_ptr_q + PTR_W'(i)].wd;
        end
      end
    end
  end

endmodule

// File: doc/reg_wb_queue.md
REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, at least 2).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports a_valid (input, 1), a_rd (input, 5), a_wd (input, 32) and a_ready (output, 1): the ALU writeback source.
REQ-005 SHALL have ports m_valid (input, 1), m_rd (input, 5), m_wd (input, 32) and m_ready (output, 1): the load-unit writeback source.
REQ-006 SHALL have ports we (output, 1), rd (output, 5) and wd (output, 32): the register-file write port.
REQ-007 SHALL have ports rs1 and rs2 (input, 5 each): the read addresses currently presented to the register file.
REQ-008 SHALL have ports fwd1_hit and fwd2_hit (output, 1 each) and fwd1_data and fwd2_data (output, 32 each): pending-write forwarding results.
REQ-009 SHALL have port count (output, clog2(DEPTH)+1 bits): current queue occupancy.

Function
REQ-010 SHALL accept a source beat in a cycle when both its valid and its ready signals are high at the rising edge.
REQ-011 SHALL compute free as DEPTH-count, with no credit for a pop in the same cycle.
REQ-012 SHALL drive a_ready high when free is 1 or more.
REQ-013 SHALL drive m_ready high when free is 2 or more, or when free is 1 or more and a_valid is low.
REQ-014 SHALL enqueue both beats when both sources are accepted in the same cycle, with the A beat ahead of the M beat in order.
REQ-015 SHALL complete the handshake for an accepted beat with rd equal to 0 but SHALL NOT enqueue that beat.
REQ-016 SHALL drive we high whenever count is not 0, with rd and wd taken combinationally from the head entry.
REQ-017 SHALL drive rd and wd to 0 when count is 0.
REQ-018 SHALL pop the head entry on every rising edge at which we is high, giving one register-file write per cycle in FIFO order.
REQ-019 SHALL make a beat accepted at edge N into an empty queue appear on we/rd/wd during cycle N+1.
REQ-020 SHALL update count as count + (number of pushes) - (pop) in a cycle with simultaneous push and pop, and count SHALL never exceed DEPTH.
REQ-021 SHALL wrap the read and write pointers modulo DEPTH.
REQ-022 SHALL drive fwd1_hit high when any valid queue entry has rd equal to rs1 and rs1 is not 0, and fwd2_hit likewise for rs2.
REQ-023 SHALL drive fwdN_data from the youngest matching entry, and SHALL drive 0 when there is no hit.
REQ-024 SHALL search only queued entries for forwarding; beats still on the source inputs SHALL be excluded.
REQ-025 SHALL compute forwarding combinationally, with zero-cycle latency.

Reset
REQ-026 SHALL clear count, both pointers, we, rd, wd, fwd1_hit, fwd2_hit, fwd1_data and fwd2_data to 0 at any rising edge with RST high.
REQ-027 SHALL let RST take priority over a simultaneous push or pop.
REQ-028 SHALL discard all queued entries on a reset applied mid-operation, issuing no further writes.
REQ-029 SHALL drive a_ready and m_ready high in the first cycle after reset when both sources are idle.
REQ-030 SHALL leave the entry storage uncleared by reset.

Structure
REQ-031 SHALL place the register-index width (5), data width (32) and the writeback-entry typedef {rd, wd} in the shared core package.
REQ-032 SHALL use no sub-module; the FIFO storage, forwarding search and ready logic SHALL be implemented inline.

Verification
REQ-033 SHALL cover single write: A beat (rd 5, 0x12345678) into an empty queue -> we=1, rd=5, wd=0x12345678 in the next cycle, then count=0.
REQ-034 SHALL cover simultaneous sources: A (rd 3, 0xA) and M (rd 4, 0xB) accepted in one cycle -> writes rd 3 then rd 4 on consecutive cycles.
REQ-035 SHALL cover back-pressure: hold sources valid with DEPTH=4 and the queue at count 3 -> a_ready=1, m_ready=0; at count 4 -> both ready low, and no beat is lost.
REQ-036 SHALL cover x0 drop: A beat with rd 0 -> a_ready handshake completes, count stays 0, we stays 0.
REQ-037 SHALL cover forwarding: queue rd 7=0x1 then rd 7=0x2 with rs1=7 and rs2=0 -> fwd1_hit=1, fwd1_data=0x2, fwd2_hit=0.
REQ-038 SHALL cover reset mid-operation: RST high with count 3 -> count=0 and we=0 in the following cycle, and no stale writes appear.
